l1_arbiter: RTL and testbench
=============================

# l1_arbiter

Two-to-one request arbiter that lets a pair of private L1 caches (cache_l1) share one L2 cache port (cache_l2 upper side). It sits between the L1 `*_low` interfaces and the L2 `*_hig` interface, in the L2 clock domain. It serializes one complete L1 transaction at a time, either a line read or a write-back. It forwards address, command and data, and returns ready and data to the granted requester.

## Interface
- `ADDR_W`, 24, address width (byte address, bit 23 selects memory bank downstream)
- `DATA_W`, 32, L1 line/transfer width
- `clk`  in  1  L2-domain clock; all state on rising edge
- `reset`  in  1  synchronous, active-low reset
- `addr_1`, `addr_2`  in  ADDR_W  request address from L1 port 1 / 2
- `data_in_1`, `data_in_2`  in  DATA_W  write data from L1 port
- `rw_1`, `rw_2`  in  1  1 = read, 0 = write
- `ce_1`, `ce_2`  in  1  request enable, held high until served
- `data_out_1`, `data_out_2`  out  DATA_W  read data to L1 port
- `RDY_1`, `RDY_2`  out  1  transaction complete for that port
- `pro_1`, `pro_2`  out  1  port currently owns the L2 (in progress)
- `addr_low`  out  ADDR_W  address to L2
- `data_low`  inout  DATA_W  shared data bus to L2
- `rw_low`  out  1  command to L2
- `ce_low`  out  1  request to L2
- `RDY_low`  in  1  L2 completion

## Operation
- States: IDLE, BUSY1, BUSY2, DONE1, DONE2. Priority pointer `prio` (1 or 2).
- IDLE: if only one `ce_x` is high, go to BUSYx. If both are high, go to BUSY`prio`. Otherwise stay.
- BUSYx: `ce_low`=1. `addr_low`=`addr_x`, `rw_low`=`rw_x`, `pro_x`=1.
  - Write (`rw_x`=0): drive `data_low`=`data_in_x`.
  - Read: `data_low` is high-Z.
  - On `RDY_low`=1, go to DONEx. On a read, capture `data_out_x`<=`data_low`.
  - If `ce_x` drops before `RDY_low`, abort to IDLE with no RDY and no data update.
- DONEx: `ce_low`=0, `data_low` is high-Z, `RDY_x`=1, `pro_x`=1. When `ce_x` is sampled low, go to IDLE and set `prio` to the other port.
- Non-granted port: `RDY`=0, `pro`=0. `data_out` holds its last captured value.
- Outside BUSY: `addr_low`=0 and `rw_low`=1. `data_low` is never driven outside BUSYx-write.
- Reset (`reset`=0 at an edge): go to IDLE, `prio`=1. All outputs are 0 except `rw_low`=1. `data_out_x`=0, `data_low` is high-Z.
- Reset mid-transaction: abandon the transaction immediately; no RDY is issued.

## Timing
- `ce_x` sampled high in IDLE at edge N gives BUSYx, `ce_low` and `pro_x` high after edge N (1-cycle grant latency).
- `RDY_low` sampled at edge M gives `RDY_x`=1 and `data_out_x` valid after edge M, together.
- `RDY_x` stays high until the edge where `ce_x` is sampled low, then drops with `pro_x`.
- Minimum turnaround between grants: 1 IDLE cycle.
- Bus outputs in BUSY/DONE are combinational from state plus the granted port's inputs. Requesters hold inputs stable while `ce_x`=1.
- Simultaneous requests: the loser keeps `ce` high and is granted on the IDLE cycle after the winner releases, because `prio` has flipped.

## Structure
- Shared package `cache_pkg`:
  - `ADDR_W`/`DATA_W` defaults
  - arbiter state enum
  - `RW_READ`=1 / `RW_WRITE`=0 constants
  - MOSI-style state codes (INVALID 2'b11, SHARED 2'b10, OWNED_CLEAN 2'b00, OWNED_DIRTY 2'b01), kept there for the cache blocks
- Single module, no sub-modules. The tri-state driver is one continuous assignment.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with both `ce` high. Expect IDLE, no `ce_low`, `data_low`=Z, `rw_low`=1. Release, and port 1 is granted first.
- Port 1 read of 24'h245678:
  - `ce_low`/`addr_low`=24'h245678/`rw_low`=1 one cycle later.
  - L2 drives 32'hDEADBEEF with `RDY_low` for 1 cycle. Next edge gives `RDY_1`=1, `data_out_1`=32'hDEADBEEF.
  - Drop `ce_1`, and `RDY_1`/`pro_1` fall.
- Port 2 write of 32'h000000AB to 24'hF20000: `data_low`=32'hAB while BUSY2, `rw_low`=0. After `RDY_low`, `RDY_2`=1 and `data_out_2` is unchanged.
- Both `ce` raised the same edge after reset:
  - Port 1 is served first and `pro_2`=0 throughout.
  - After `ce_1` drops, port 2 is granted one IDLE cycle later.
  - Repeat the collision: port 2 now wins.
- Abort: port 1 read, drop `ce_1` before `RDY_low`. Expect return to IDLE, `RDY_1` never asserts, and `data_out_1` is unchanged.
- Reset asserted in BUSY2: next cycle IDLE, `pro_2`=0, `RDY_2`=0, `data_low`=Z.

Source files
------------

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the L1/L2 cache blocks and the L1 arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default address and line widths
//   arb_state_e             : l1_arbiter grant state machine
//   RW_READ / RW_WRITE      : command encoding on the rw lines
//   mosi_state_e            : line coherence codes used by the cache blocks
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int unsigned DEF_ADDR_W = 24;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StBusy1,
        StBusy2,
        StDone1,
        StDone2
    } arb_state_e;

    typedef enum logic [1:0] {
        MosiOwnedClean = 2'b00,
        MosiOwnedDirty = 2'b01,
        MosiShared     = 2'b10,
        MosiInvalid    = 2'b11
    } mosi_state_e;

endpackage

// File: rtl/l1_arbiter.sv
// ---------------------------------------------------------------------------
// l1_arbiter
// Two-to-one arbiter letting two L1 caches share a single L2 port. One full
// L1 transaction (line read or write-back) is carried at a time.
//   clk, reset            : L2-domain clock, synchronous active-low reset
//   addr_x, data_in_x,
//   rw_x, ce_x            : request from L1 port x (held while ce_x = 1)
//   data_out_x            : last read data captured for port x
//   RDY_x                 : port x transaction complete (until ce_x drops)
//   pro_x                 : port x currently owns the L2 port
//   addr_low, rw_low,
//   ce_low, RDY_low       : L2 request side
//   data_low              : shared bidirectional data bus to the L2
// ---------------------------------------------------------------------------
module l1_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic              rw_1,
    input  logic              rw_2,
    input  logic              ce_1,
    input  logic              ce_2,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2,
    output logic              RDY_1,
    output logic              RDY_2,
    output logic              pro_1,
    output logic              pro_2,
    output logic [ADDR_W-1:0] addr_low,
    inout  wire  [DATA_W-1:0] data_low,
    output logic              rw_low,
    output logic              ce_low,
    input  logic              RDY_low
);

    arb_state_e        r_state;
    logic              r_prio_2;    // 1: port 2 wins a simultaneous request
    logic [DATA_W-1:0] r_data_out_1;
    logic [DATA_W-1:0] r_data_out_2;

    logic              w_busy_1;
    logic              w_busy_2;
    logic              w_drive;
    logic [DATA_W-1:0] w_wdata;

    assign w_busy_1 = (r_state == StBusy1);
    assign w_busy_2 = (r_state == StBusy2);

    // Only a granted write owns the bus; every other state leaves it to the L2.
    assign w_drive  = (w_busy_1 && (rw_1 == RW_WRITE)) || (w_busy_2 && (rw_2 == RW_WRITE));
    assign w_wdata  = w_busy_2 ? data_in_2 : data_in_1;
    assign data_low = w_drive ? w_wdata : {DATA_W{1'bz}};

    always_comb begin
        ce_low   = w_busy_1 || w_busy_2;
        addr_low = '0;
        rw_low   = RW_READ;
        if (w_busy_1) begin
            addr_low = addr_1;
            rw_low   = rw_1;
        end else if (w_busy_2) begin
            addr_low = addr_2;
            rw_low   = rw_2;
        end
    end

    assign RDY_1      = (r_state == StDone1);
    assign RDY_2      = (r_state == StDone2);
    assign pro_1      = w_busy_1 || (r_state == StDone1);
    assign pro_2      = w_busy_2 || (r_state == StDone2);
    assign data_out_1 = r_data_out_1;
    assign data_out_2 = r_data_out_2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_prio_2     <= 1'b0;
            r_data_out_1 <= '0;
            r_data_out_2 <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (ce_1 && ce_2) begin
                        r_state <= r_prio_2 ? StBusy2 : StBusy1;
                    end else if (ce_1) begin
                        r_state <= StBusy1;
                    end else if (ce_2) begin
                        r_state <= StBusy2;
                    end
                end
                // A dropped request wins over a same-edge completion: abort cleanly.
                StBusy1: begin
                    if (!ce_1) begin
                        r_state <= StIdle;
                    end else if (RDY_low) begin
                        r_state <= StDone1;
                        if (rw_1 == RW_READ) begin
                            r_data_out_1 <= data_low;
                        end
                    end
                end
                StBusy2: begin
                    if (!ce_2) begin
                        r_state <= StIdle;
                    end else if (RDY_low) begin
                        r_state <= StDone2;
                        if (rw_2 == RW_READ) begin
                            r_data_out_2 <= data_low;
                        end
                    end
                end
                StDone1: begin
                    if (!ce_1) begin
                        r_state  <= StIdle;
                        r_prio_2 <= 1'b1;
                    end
                end
                StDone2: begin
                    if (!ce_2) begin
                        r_state  <= StIdle;
                        r_prio_2 <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_arbiter.sv
module tb_l1_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] addr_1, addr_2;
    logic [31:0] data_in_1, data_in_2;
    logic        rw_1, rw_2, ce_1, ce_2;
    logic [31:0] data_out_1, data_out_2;
    logic        RDY_1, RDY_2, pro_1, pro_2;
    logic [23:0] addr_low;
    wire  [31:0] data_low;
    logic        rw_low, ce_low, RDY_low;

    // L2-side model driver for the shared bus
    logic        l2_en;
    logic [31:0] l2_data;
    assign data_low = l2_en ? l2_data : 32'bz;

    localparam logic [31:0] PROBE = 32'h5A5A_A5A5;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l1_arbiter #(.ADDR_W(24), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr_1     (addr_1),
        .addr_2     (addr_2),
        .data_in_1  (data_in_1),
        .data_in_2  (data_in_2),
        .rw_1       (rw_1),
        .rw_2       (rw_2),
        .ce_1       (ce_1),
        .ce_2       (ce_2),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .RDY_1      (RDY_1),
        .RDY_2      (RDY_2),
        .pro_1      (pro_1),
        .pro_2      (pro_2),
        .addr_low   (addr_low),
        .data_low   (data_low),
        .rw_low     (rw_low),
        .ce_low     (ce_low),
        .RDY_low    (RDY_low)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus released by the arbiter: a value placed by the L2 model must reach the net.
    task automatic chk_released(input string tag);
        l2_en   = 1'b1;
        l2_data = PROBE;
        #1;
        chk(tag, {32'd0, data_low}, {32'd0, PROBE});
        l2_en   = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; RDY_low = 1'b0; l2_en = 1'b0; l2_data = '0;
        addr_1 = 24'h245678; rw_1 = 1'b1; data_in_1 = 32'h1111_1111; ce_1 = 1'b1;
        addr_2 = 24'hF20000; rw_2 = 1'b0; data_in_2 = 32'h0000_00AB; ce_2 = 1'b1;

        // Reset held two cycles with both requests pending
        step(); step();
        chk("rst_ce_low", ce_low, 0);
        chk("rst_rw_low", rw_low, 1);
        chk("rst_addr_low", addr_low, 0);
        chk("rst_pro", {pro_1, pro_2}, 0);
        chk("rst_rdy", {RDY_1, RDY_2}, 0);
        chk("rst_dout", {data_out_1, data_out_2}, 0);
        chk_released("rst_bus");

        // Release: port 1 granted first, port 1 read
        reset = 1'b1;
        step();
        chk("rd1_ce_low", ce_low, 1);
        chk("rd1_addr", addr_low, 24'h245678);
        chk("rd1_rw", rw_low, 1);
        chk("rd1_pro", {pro_1, pro_2}, 2'b10);
        chk("rd1_rdy_early", RDY_1, 0);
        chk_released("rd1_bus");
        l2_en = 1'b1; l2_data = 32'hDEADBEEF; RDY_low = 1'b1;
        step();
        l2_en = 1'b0; RDY_low = 1'b0;
        chk("rd1_rdy", RDY_1, 1);
        chk("rd1_dout", data_out_1, 32'hDEADBEEF);
        chk("done1_ce_low", ce_low, 0);
        chk("done1_addr", addr_low, 0);
        chk("done1_rw", rw_low, 1);
        chk("done1_pro", {pro_1, pro_2}, 2'b10);
        step();
        chk("done1_hold", RDY_1, 1);
        ce_1 = 1'b0;
        step();
        chk("rel1_rdy", RDY_1, 0);
        chk("rel1_pro", {pro_1, pro_2}, 0);
        chk("idle_gap_ce_low", ce_low, 0);

        // Loser of the collision now granted: port 2 write
        step();
        chk("wr2_pro", {pro_1, pro_2}, 2'b01);
        chk("wr2_addr", addr_low, 24'hF20000);
        chk("wr2_rw", rw_low, 0);
        chk("wr2_bus", data_low, 32'h0000_00AB);
        RDY_low = 1'b1;
        step();
        RDY_low = 1'b0;
        chk("wr2_rdy", RDY_2, 1);
        chk("wr2_dout", data_out_2, 0);
        chk_released("done2_bus");
        ce_2 = 1'b0;
        step();
        chk("rel2_rdy_pro", {RDY_2, pro_2}, 0);

        // Collision with prio back on port 1
        ce_1 = 1'b1; ce_2 = 1'b1;
        step();
        chk("colB_pro", {pro_1, pro_2}, 2'b10);
        l2_en = 1'b1; l2_data = 32'h1234_5678; RDY_low = 1'b1;
        step();
        l2_en = 1'b0; RDY_low = 1'b0;
        chk("colB_dout1", data_out_1, 32'h1234_5678);
        chk("colB_pro2_done", pro_2, 0);
        ce_1 = 1'b0; ce_2 = 1'b0;
        step();
        chk("colB_idle", {pro_1, pro_2, ce_low}, 0);

        // Repeat collision: prio flipped, port 2 wins
        ce_1 = 1'b1; ce_2 = 1'b1;
        step();
        chk("colC_pro", {pro_1, pro_2}, 2'b01);
        chk("colC_addr", addr_low, 24'hF20000);
        RDY_low = 1'b1;
        step();
        RDY_low = 1'b0;
        chk("colC_rdy", {RDY_1, RDY_2}, 2'b01);
        ce_2 = 1'b0; ce_1 = 1'b0;
        step();

        // Abort: port 1 read dropped before completion
        addr_1 = 24'h000100; ce_1 = 1'b1;
        step();
        chk("abort_busy", {pro_1, ce_low}, 2'b11);
        chk("abort_addr", addr_low, 24'h000100);
        ce_1 = 1'b0;
        step();
        chk("abort_idle", {pro_1, RDY_1, ce_low}, 0);
        step();
        chk("abort_no_rdy", RDY_1, 0);
        chk("abort_dout", data_out_1, 32'h1234_5678);

        // Reset asserted in BUSY2 (write, so the bus is being driven)
        ce_2 = 1'b1; data_in_2 = 32'hCAFE_0001;
        step();
        chk("busy2_bus", data_low, 32'hCAFE_0001);
        chk("busy2_pro", pro_2, 1);
        reset = 1'b0;
        step();
        chk("rst_busy2", {pro_2, RDY_2, ce_low}, 0);
        chk("rst_busy2_rw", rw_low, 1);
        chk("rst_busy2_dout1", data_out_1, 0);
        chk_released("rst_busy2_bus");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
